// File: rtl/tdm_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: lock-state encoding and
// lane/slot sizing constants.
package tdm_pkg;

    localparam int NUM_LANES = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } sync_state_e;

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Frame-lock controller: tracks the slot position, counts missing frame markers,
// and decides for each valid sample whether it is routed and to which lane.
module tdm_slot_ctrl
    import tdm_pkg::*;
#(
    parameter int MAX_MISS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dv,
    input  logic              frame,
    output logic              route_en,
    output logic [SLOT_W-1:0] route_lane,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              frm_done,
    output logic              sync_err,
    output logic [7:0]        err_cnt
);

    localparam logic [2:0]        MISS_LIMIT = 3'(MAX_MISS);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_LANES - 1);

    sync_state_e       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [2:0]        miss_q, miss_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              frm_done_q, frm_done_d;
    logic              sync_err_q, sync_err_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        slot_d     = slot_q;
        miss_d     = miss_q;
        err_cnt_d  = err_cnt_q;
        frm_done_d = 1'b0;
        sync_err_d = 1'b0;
        route_en   = 1'b0;
        route_lane = '0;

        if (dv) begin
            unique case (state_q)
                HUNT: begin
                    if (frame) begin
                        route_en = 1'b1;
                        slot_d   = SLOT_W'(1);
                        miss_d   = '0;
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
                    if (frame) begin
                        // Marker always realigns to slot 0; off-position it is an error.
                        route_en   = 1'b1;
                        slot_d     = SLOT_W'(1);
                        miss_d     = '0;
                        sync_err_d = (slot_q != '0);
                    end else if (slot_q != '0) begin
                        route_en   = 1'b1;
                        route_lane = slot_q;
                        slot_d     = slot_q + SLOT_W'(1);
                        frm_done_d = (slot_q == LAST_SLOT);
                    end else begin
                        sync_err_d = 1'b1;
                        if (miss_q + 3'd1 >= MISS_LIMIT) begin
                            state_d = HUNT;
                            slot_d  = '0;
                            miss_d  = '0;
                        end else begin
                            route_en = 1'b1;
                            slot_d   = SLOT_W'(1);
                            miss_d   = miss_q + 3'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (sync_err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            slot_q     <= '0;
            miss_q     <= '0;
            err_cnt_q  <= '0;
            frm_done_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            miss_q     <= miss_d;
            err_cnt_q  <= err_cnt_d;
            frm_done_q <= frm_done_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign slot     = slot_q;
    assign locked   = (state_q == LOCK);
    assign frm_done = frm_done_q;
    assign sync_err = sync_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: routes each valid sample of a framed stream to one of
// four registered lanes, with a one-cycle valid pulse per lane update.
module tdm_demux_1_4
    import tdm_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_MISS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      D,
    input  logic              DV,
    input  logic              FRAME,
    output logic [W-1:0]      Y0,
    output logic [W-1:0]      Y1,
    output logic [W-1:0]      Y2,
    output logic [W-1:0]      Y3,
    output logic              V0,
    output logic              V1,
    output logic              V2,
    output logic              V3,
    output logic [SLOT_W-1:0] SLOT,
    output logic              LOCKED,
    output logic              FRM_DONE,
    output logic              SYNC_ERR,
    output logic [7:0]        ERR_CNT
);

    logic              route_en;
    logic [SLOT_W-1:0] route_lane;

    logic [W-1:0]         y_q [NUM_LANES];
    logic [W-1:0]         y_d [NUM_LANES];
    logic [NUM_LANES-1:0] v_q, v_d;

    tdm_slot_ctrl #(
        .MAX_MISS (MAX_MISS)
    ) u_slot_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .dv         (DV),
        .frame      (FRAME),
        .route_en   (route_en),
        .route_lane (route_lane),
        .slot       (SLOT),
        .locked     (LOCKED),
        .frm_done   (FRM_DONE),
        .sync_err   (SYNC_ERR),
        .err_cnt    (ERR_CNT)
    );

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            y_d[i] = y_q[i];
            v_d[i] = route_en && (route_lane == SLOT_W'(i));
            if (v_d[i]) begin
                y_d[i] = D;
            end
        end
    end

    // Lane registers are few and must read 0 after reset, so they are reset explicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                y_q[i] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                y_q[i] <= y_d[i];
            end
            v_q <= v_d;
        end
    end

    assign Y0 = y_q[0];
    assign Y1 = y_q[1];
    assign Y2 = y_q[2];
    assign Y3 = y_q[3];
    assign V0 = v_q[0];
    assign V1 = v_q[1];
    assign V2 = v_q[2];
    assign V3 = v_q[3];

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed self-checking bench for tdm_demux_1_4 (W=1, MAX_MISS=2).
module tb_tdm_demux_1_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] D;
    logic       DV;
    logic       FRAME;
    logic [0:0] Y0, Y1, Y2, Y3;
    logic       V0, V1, V2, V3;
    logic [1:0] SLOT;
    logic       LOCKED;
    logic       FRM_DONE;
    logic       SYNC_ERR;
    logic [7:0] ERR_CNT;

    int passed = 0;
    int total  = 0;

    tdm_demux_1_4 #(
        .W        (1),
        .MAX_MISS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .D        (D),
        .DV       (DV),
        .FRAME    (FRAME),
        .Y0       (Y0),
        .Y1       (Y1),
        .Y2       (Y2),
        .Y3       (Y3),
        .V0       (V0),
        .V1       (V1),
        .V2       (V2),
        .V3       (V3),
        .SLOT     (SLOT),
        .LOCKED   (LOCKED),
        .FRM_DONE (FRM_DONE),
        .SYNC_ERR (SYNC_ERR),
        .ERR_CNT  (ERR_CNT)
    );

    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic r, input logic dv, input logic fr, input logic d);
        rst_n = r;
        DV    = dv;
        FRAME = fr;
        D     = d;
        @(posedge clk);
        #1;
        DV    = 1'b0;
        FRAME = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if ({Y3, Y2, Y1, Y0, V3, V2, V1, V0} !== 8'h00) begin
            $display("FAIL reset_lanes: got Y=%b V=%b, expected Y=0000 V=0000",
                     {Y3, Y2, Y1, Y0}, {V3, V2, V1, V0});
        end else passed++;
        total++;
        if ({SLOT, LOCKED, FRM_DONE, SYNC_ERR, ERR_CNT} !== 13'h0) begin
            $display("FAIL reset_ctrl: got SLOT=%0d LOCKED=%b FRM_DONE=%b SYNC_ERR=%b ERR_CNT=%0d, expected all 0",
                     SLOT, LOCKED, FRM_DONE, SYNC_ERR, ERR_CNT);
        end else passed++;
    endtask

    task automatic test_hunt_discard();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            total++;
            if ({V3, V2, V1, V0, LOCKED, SLOT, Y0} !== 8'h00) begin
                $display("FAIL hunt_discard[%0d]: got V=%b LOCKED=%b SLOT=%0d Y0=%b, expected V=0000 LOCKED=0 SLOT=0 Y0=0",
                         i, {V3, V2, V1, V0}, LOCKED, SLOT, Y0);
            end else passed++;
        end
    endtask

    task automatic test_clean_frame();
        logic [3:0] exp_v [4];
        logic [1:0] exp_slot [4];
        logic       d_in [4];
        exp_v    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_slot = '{2'd1, 2'd2, 2'd3, 2'd0};
        d_in     = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), d_in[i]);
            total++;
            if ({V3, V2, V1, V0} !== exp_v[i] || SLOT !== exp_slot[i] || LOCKED !== 1'b1
                || FRM_DONE !== (i == 3) || SYNC_ERR !== 1'b0) begin
                $display("FAIL clean_frame[%0d]: got V=%b SLOT=%0d LOCKED=%b FRM_DONE=%b SYNC_ERR=%b, expected V=%b SLOT=%0d LOCKED=1 FRM_DONE=%b SYNC_ERR=0",
                         i, {V3, V2, V1, V0}, SLOT, LOCKED, FRM_DONE, SYNC_ERR,
                         exp_v[i], exp_slot[i], (i == 3));
            end else passed++;
        end
        total++;
        if ({Y0, Y1, Y2, Y3} !== 4'b0111) begin
            $display("FAIL clean_frame_lanes: got Y0..Y3=%b, expected 0111", {Y0, Y1, Y2, Y3});
        end else passed++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({V3, V2, V1, V0, FRM_DONE} !== 5'b0) begin
            $display("FAIL pulse_clear: got V=%b FRM_DONE=%b, expected V=0000 FRM_DONE=0",
                     {V3, V2, V1, V0}, FRM_DONE);
        end else passed++;
    endtask

    task automatic test_dv_gaps();
        logic       d_in [4];
        logic [1:0] exp_slot [4];
        d_in     = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_slot = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i == 0), d_in[i]);
            step(1'b1, 1'b0, 1'b1, ~d_in[i]);
            total++;
            if ({V3, V2, V1, V0} !== 4'b0 || SLOT !== exp_slot[i]) begin
                $display("FAIL dv_gap[%0d]: got V=%b SLOT=%0d, expected V=0000 SLOT=%0d",
                         i, {V3, V2, V1, V0}, SLOT, exp_slot[i]);
            end else passed++;
        end
        total++;
        if ({Y0, Y1, Y2, Y3} !== 4'b1011) begin
            $display("FAIL dv_gap_lanes: got Y0..Y3=%b, expected 1011", {Y0, Y1, Y2, Y3});
        end else passed++;
    endtask

    task automatic test_misplaced_frame();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (Y0 !== 1'b0 || SLOT !== 2'd2) begin
            $display("FAIL misplaced_setup: got Y0=%b SLOT=%0d, expected Y0=0 SLOT=2", Y0, SLOT);
        end else passed++;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (Y0 !== 1'b1 || {V3, V2, V1, V0} !== 4'b0001 || SYNC_ERR !== 1'b1 || ERR_CNT !== 8'd1
            || SLOT !== 2'd1 || FRM_DONE !== 1'b0 || LOCKED !== 1'b1) begin
            $display("FAIL misplaced_frame: got Y0=%b V=%b SYNC_ERR=%b ERR_CNT=%0d SLOT=%0d FRM_DONE=%b LOCKED=%b, expected Y0=1 V=0001 SYNC_ERR=1 ERR_CNT=1 SLOT=1 FRM_DONE=0 LOCKED=1",
                     Y0, {V3, V2, V1, V0}, SYNC_ERR, ERR_CNT, SLOT, FRM_DONE, LOCKED);
        end else passed++;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (SYNC_ERR !== 1'b0 || ERR_CNT !== 8'd1) begin
            $display("FAIL sync_err_clear: got SYNC_ERR=%b ERR_CNT=%0d, expected SYNC_ERR=0 ERR_CNT=1",
                     SYNC_ERR, ERR_CNT);
        end else passed++;
    endtask

    task automatic test_lock_loss();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Lock with a full frame, finishing at SLOT=0.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b0);
        // First missing marker: still routed to Y0.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (SYNC_ERR !== 1'b1 || ERR_CNT !== 8'd1 || {V3, V2, V1, V0} !== 4'b0001
            || Y0 !== 1'b1 || LOCKED !== 1'b1 || SLOT !== 2'd1) begin
            $display("FAIL miss_first: got SYNC_ERR=%b ERR_CNT=%0d V=%b Y0=%b LOCKED=%b SLOT=%0d, expected SYNC_ERR=1 ERR_CNT=1 V=0001 Y0=1 LOCKED=1 SLOT=1",
                     SYNC_ERR, ERR_CNT, {V3, V2, V1, V0}, Y0, LOCKED, SLOT);
        end else passed++;
        for (int i = 1; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        // Second consecutive missing marker drops lock and discards the sample.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (SYNC_ERR !== 1'b1 || ERR_CNT !== 8'd2 || {V3, V2, V1, V0} !== 4'b0000
            || Y0 !== 1'b1 || LOCKED !== 1'b0 || SLOT !== 2'd0) begin
            $display("FAIL miss_lock_loss: got SYNC_ERR=%b ERR_CNT=%0d V=%b Y0=%b LOCKED=%b SLOT=%0d, expected SYNC_ERR=1 ERR_CNT=2 V=0000 Y0=1 LOCKED=0 SLOT=0",
                     SYNC_ERR, ERR_CNT, {V3, V2, V1, V0}, Y0, LOCKED, SLOT);
        end else passed++;
        // Back in HUNT: no further errors for unmarked samples.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (SYNC_ERR !== 1'b0 || ERR_CNT !== 8'd2 || {V3, V2, V1, V0} !== 4'b0) begin
            $display("FAIL hunt_after_loss: got SYNC_ERR=%b ERR_CNT=%0d V=%b, expected SYNC_ERR=0 ERR_CNT=2 V=0000",
                     SYNC_ERR, ERR_CNT, {V3, V2, V1, V0});
        end else passed++;
    endtask

    task automatic test_reset_mid_frame();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (SLOT !== 2'd2 || Y1 !== 1'b1) begin
            $display("FAIL mid_frame_setup: got SLOT=%0d Y1=%b, expected SLOT=2 Y1=1", SLOT, Y1);
        end else passed++;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if ({Y3, Y2, Y1, Y0, V3, V2, V1, V0} !== 8'h00 || SLOT !== 2'd0 || LOCKED !== 1'b0
            || ERR_CNT !== 8'd0 || SYNC_ERR !== 1'b0 || FRM_DONE !== 1'b0) begin
            $display("FAIL mid_frame_reset: got Y=%b V=%b SLOT=%0d LOCKED=%b ERR_CNT=%0d, expected Y=0000 V=0000 SLOT=0 LOCKED=0 ERR_CNT=0",
                     {Y3, Y2, Y1, Y0}, {V3, V2, V1, V0}, SLOT, LOCKED, ERR_CNT);
        end else passed++;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (Y0 !== 1'b1 || {V3, V2, V1, V0} !== 4'b0001 || SLOT !== 2'd1 || LOCKED !== 1'b1
            || SYNC_ERR !== 1'b0) begin
            $display("FAIL relock_after_reset: got Y0=%b V=%b SLOT=%0d LOCKED=%b SYNC_ERR=%b, expected Y0=1 V=0001 SLOT=1 LOCKED=1 SYNC_ERR=0",
                     Y0, {V3, V2, V1, V0}, SLOT, LOCKED, SYNC_ERR);
        end else passed++;
    endtask

    task automatic test_err_saturate();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        // Each further marker lands on SLOT=1, so every cycle is a misplaced-marker error.
        for (int i = 0; i < 254; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (ERR_CNT !== 8'd254) begin
            $display("FAIL err_cnt_254: got ERR_CNT=%0d, expected 254", ERR_CNT);
        end else passed++;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (ERR_CNT !== 8'd255 || SYNC_ERR !== 1'b1) begin
            $display("FAIL err_cnt_255: got ERR_CNT=%0d SYNC_ERR=%b, expected ERR_CNT=255 SYNC_ERR=1",
                     ERR_CNT, SYNC_ERR);
        end else passed++;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (ERR_CNT !== 8'd255 || SYNC_ERR !== 1'b1) begin
            $display("FAIL err_cnt_saturate: got ERR_CNT=%0d SYNC_ERR=%b, expected ERR_CNT=255 SYNC_ERR=1",
                     ERR_CNT, SYNC_ERR);
        end else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        DV    = 1'b0;
        FRAME = 1'b0;
        D     = 1'b0;
        #1;
        test_reset();
        test_hunt_discard();
        test_clean_frame();
        test_dv_gaps();
        test_misplaced_frame();
        test_lock_loss();
        test_reset_mid_frame();
        test_err_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
